reqack_fifo: RTL and testbench

Elastic FIFO buffer for the req/ack token protocol used between `producer`, `async_operator` and `consumer`. Its upstream port acts as an initiator and pulls tokens from a responder (a `producer` or an operator `ack_r`/`dout` pair). Its downstream port acts as a responder and serves tokens to an initiator (a `consumer` or an operator `req_l`). It is inserted on long or unbalanced dataflow edges to absorb slack without changing token order or values.

---
 rtl/reqack_fifo.sv | 64 ++++++
 tb/tb_reqack_fifo.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/reqack_fifo.sv
// reqack_fifo: elastic FIFO that pulls tokens over req/ack upstream and serves them over req/ack downstream.
module reqack_fifo #(
    parameter int data_width = 32,
    parameter int depth_log2 = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    output logic                  req_l,
    input  logic                  ack_l,
    input  logic [data_width-1:0] din,
    input  logic                  req_r,
    output logic                  ack_r,
    output logic [data_width-1:0] dout,
    output logic [31:0]           count,
    output logic [depth_log2:0]   level
);
    localparam int depth = 1 << depth_log2;
    localparam int pw = depth_log2;
    localparam int lw = depth_log2 + 1;
    logic [data_width-1:0] mem_q [depth];
    logic [pw-1:0]         wp_q, rp_q;
    logic [lw-1:0]         level_q, level_d;
    logic                  req_q, req_d, ack_q;
    logic [data_width-1:0] dout_q;
    logic [31:0]           count_q;
    logic                  not_full, wr, rd;
    // decisions use the registered level, so a token cannot leave on the edge it lands
    always_comb begin
        not_full = level_q != lw'(depth);
        wr = ack_l && not_full;
        rd = req_r && !ack_q && level_q != '0;
        req_d = ack_l ? 1'b0 : (not_full && !req_q) ? 1'b1 : req_q;
        level_d = level_q + lw'(wr) - lw'(rd);
    end
    always_ff @(posedge clk) begin
        if (wr) mem_q[wp_q] <= din;
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            wp_q <= '0;
            rp_q <= '0;
            level_q <= '0;
            req_q <= 1'b0;
            ack_q <= 1'b0;
            dout_q <= '0;
            count_q <= '0;
        end else begin
            req_q <= req_d;
            ack_q <= rd;
            level_q <= level_d;
            if (wr) wp_q <= wp_q + pw'(1);
            if (rd) begin
                rp_q <= rp_q + pw'(1);
                dout_q <= mem_q[rp_q];
                count_q <= count_q + 32'd1;
            end
        end
    end
    assign req_l = req_q;
    assign ack_r = ack_q;
    assign dout = dout_q;
    assign count = count_q;
    assign level = level_q;
endmodule

// File: tb/tb_reqack_fifo.sv
// tb_reqack_fifo: checks a depth-4 and a depth-2 reqack_fifo against a token-log reference model.
module tb_reqack_fifo;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_v[2], ack_v[2], rr_v[2];
    logic [31:0] din_v[2];
    logic        rq4, ar4, rq2, ar2;
    logic [31:0] do4, do2, c4, c2;
    logic [2:0]  l4;
    logic [1:0]  l2;
    logic        rq[2], ar[2];
    logic [31:0] dq[2], cq[2];
    logic [2:0]  lv[2];

    always_comb begin
        rq[0] = rq4; ar[0] = ar4; dq[0] = do4; cq[0] = c4; lv[0] = l4;
        rq[1] = rq2; ar[1] = ar2; dq[1] = do2; cq[1] = c2; lv[1] = {1'b0, l2};
    end

    reqack_fifo #(.data_width(32), .depth_log2(2)) u4 (
        .clk(clk), .rst(rst_v[0]), .req_l(rq4), .ack_l(ack_v[0]), .din(din_v[0]),
        .req_r(rr_v[0]), .ack_r(ar4), .dout(do4), .count(c4), .level(l4));
    reqack_fifo #(.data_width(32), .depth_log2(1)) u2 (
        .clk(clk), .rst(rst_v[1]), .req_l(rq2), .ack_l(ack_v[1]), .din(din_v[1]),
        .req_r(rr_v[1]), .ack_r(ar2), .dout(do2), .count(c2), .level(l2));

    int checks = 0;
    int errors = 0;
    int dep[2] = '{4, 2};

    // reference: every token ever accepted is logged; occupancy is writes minus reads
    int unsigned hist[2][2048];
    int unsigned m_w[2], m_r[2];
    logic        m_req[2], m_ack[2];
    logic [31:0] m_dout[2];

    typedef struct packed {
        logic rst, ack, rr;
        logic [31:0] din;
        logic rq, ar;
        logic [31:0] dout, cnt;
        logic [2:0] lvl;
    } vec_t;
    vec_t tbl[12];

    function automatic vec_t mk(logic r, logic a, logic rr, logic [31:0] d, logic q, logic ak,
                                logic [31:0] o, logic [31:0] c, logic [2:0] l);
        vec_t v;
        v.rst = r; v.ack = a; v.rr = rr; v.din = d;
        v.rq = q; v.ar = ak; v.dout = o; v.cnt = c; v.lvl = l;
        return v;
    endfunction

    task automatic chk(string nm, logic [127:0] act, logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic model_edge(int k);
        int lvl;
        logic rd, wr;
        if (rst_v[k]) begin
            m_w[k] = 0; m_r[k] = 0; m_req[k] = 1'b0; m_ack[k] = 1'b0; m_dout[k] = '0;
        end else begin
            lvl = int'(m_w[k] - m_r[k]);
            rd = rr_v[k] && !m_ack[k] && lvl > 0;
            wr = ack_v[k] && lvl < dep[k];
            m_ack[k] = rd;
            if (rd) begin
                m_dout[k] = hist[k][m_r[k] % 2048];
                m_r[k]++;
            end
            if (wr) begin
                hist[k][m_w[k] % 2048] = din_v[k];
                m_w[k]++;
            end
            if (ack_v[k]) m_req[k] = 1'b0;
            else if (lvl < dep[k]) m_req[k] = 1'b1;
        end
    endtask

    task automatic tick();
        @(posedge clk);
        for (int k = 0; k < 2; k++) model_edge(k);
        #1;
        for (int k = 0; k < 2; k++)
            chk($sformatf("model%0d", k), {rq[k], ar[k], dq[k], cq[k], lv[k]},
                {m_req[k], m_ack[k], m_dout[k], m_r[k], 3'(m_w[k] - m_r[k])});
    endtask

    task automatic do_reset();
        for (int k = 0; k < 2; k++) begin
            rst_v[k] = 1'b1; ack_v[k] = 1'b0; rr_v[k] = 1'b0; din_v[k] = '0;
        end
        tick();
        rst_v[0] = 1'b0;
        rst_v[1] = 1'b0;
    endtask

    int   sent, got, first, last, rq_rise;
    logic any, stuck;
    int   lim[2] = '{1000, 200};
    int   s_sent[2], s_rcv[2], s_max[2];

    initial begin
        tbl[0]  = mk(1, 0, 0,  0, 0, 0,  0, 0, 0);
        tbl[1]  = mk(0, 0, 1,  0, 1, 0,  0, 0, 0);
        tbl[2]  = mk(0, 1, 1,  7, 0, 0,  0, 0, 1);
        tbl[3]  = mk(0, 0, 1,  0, 1, 1,  7, 1, 0);
        tbl[4]  = mk(0, 0, 1,  0, 1, 0,  7, 1, 0);
        tbl[5]  = mk(0, 1, 0,  9, 0, 0,  7, 1, 1);
        tbl[6]  = mk(0, 0, 0,  0, 1, 0,  7, 1, 1);
        tbl[7]  = mk(0, 1, 1, 10, 0, 1,  9, 2, 1);
        tbl[8]  = mk(0, 0, 1,  0, 1, 0,  9, 2, 1);
        tbl[9]  = mk(0, 0, 1,  0, 1, 1, 10, 3, 0);
        tbl[10] = mk(1, 1, 1, 55, 0, 0,  0, 0, 0);
        tbl[11] = mk(0, 0, 0,  0, 1, 0,  0, 0, 0);

        do_reset();
        for (int i = 0; i < 12; i++) begin
            rst_v[0] = tbl[i].rst; ack_v[0] = tbl[i].ack; din_v[0] = tbl[i].din; rr_v[0] = tbl[i].rr;
            tick();
            chk($sformatf("vec%0d", i), {rq[0], ar[0], dq[0], cq[0], lv[0]},
                {tbl[i].rq, tbl[i].ar, tbl[i].dout, tbl[i].cnt, tbl[i].lvl});
        end

        do_reset();
        sent = 0; stuck = 1'b0;
        for (int c = 0; c < 40; c++) begin
            ack_v[0] = rq[0] && sent < 4;
            if (ack_v[0]) begin din_v[0] = 32'(sent); sent++; end
            tick();
            if (c >= 15) stuck |= (rq[0] !== 1'b0) || (lv[0] !== 3'd4);
        end
        chk("fill_level", lv[0], 4);
        chk("fill_hold", stuck, 0);
        ack_v[0] = 1'b0; rr_v[0] = 1'b1;
        got = 0; first = -1; last = -1; rq_rise = -1;
        for (int c = 0; c < 20; c++) begin
            tick();
            if (ar[0]) begin
                chk($sformatf("fill_dout%0d", got), dq[0], got);
                if (got > 0) chk("fill_gap", c - last, 2);
                if (first < 0) first = c;
                last = c;
                got++;
            end
            if (rq[0] && rq_rise < 0) rq_rise = c;
        end
        chk("fill_reads", got, 4);
        chk("fill_req_rise", rq_rise - first, 1);

        do_reset();
        rr_v[0] = 1'b1; any = 1'b0;
        for (int c = 0; c < 20; c++) begin
            tick();
            any |= ar[0];
        end
        chk("empty_ack", any, 0);
        chk("empty_count", cq[0], 0);

        do_reset();
        sent = 0;
        for (int c = 0; c < 30 && !(sent == 3 && rq[0]); c++) begin
            ack_v[0] = rq[0] && sent < 3;
            if (ack_v[0]) begin din_v[0] = 32'(100 + sent); sent++; end
            tick();
        end
        chk("rst_pre_level", lv[0], 3);
        rst_v[0] = 1'b1; ack_v[0] = 1'b1; din_v[0] = 999;
        tick();
        rst_v[0] = 1'b0; ack_v[0] = 1'b0;
        chk("rst_state", {rq[0], ar[0], dq[0], cq[0], lv[0]}, 0);
        rr_v[0] = 1'b1;
        tick();
        chk("rst_req_after", {rq[0], lv[0]}, {1'b1, 3'd0});
        any = 1'b0;
        for (int c = 0; c < 10; c++) begin
            tick();
            any |= ar[0];
        end
        chk("rst_no_token", any, 0);

        do_reset();
        for (int k = 0; k < 2; k++) begin s_sent[k] = 0; s_rcv[k] = 0; s_max[k] = 0; end
        for (int c = 0; c < 20000 && (s_rcv[0] < lim[0] || s_rcv[1] < lim[1]); c++) begin
            for (int k = 0; k < 2; k++) begin
                ack_v[k] = rq[k] && s_sent[k] < lim[k] && $urandom_range(99) >= 30;
                if (ack_v[k]) begin din_v[k] = 32'(s_sent[k]); s_sent[k]++; end
                rr_v[k] = $urandom_range(99) >= 30;
            end
            tick();
            for (int k = 0; k < 2; k++) begin
                if (ar[k]) begin
                    chk($sformatf("stream%0d_tok", k), dq[k], s_rcv[k]);
                    s_rcv[k]++;
                end
                if (int'(lv[k]) > s_max[k]) s_max[k] = int'(lv[k]);
            end
        end
        for (int k = 0; k < 2; k++) begin
            chk($sformatf("stream%0d_done", k), s_rcv[k], lim[k]);
            chk($sformatf("stream%0d_maxlevel", k), s_max[k] <= dep[k], 1);
            chk($sformatf("stream%0d_end", k), {cq[k], lv[k]}, {32'(lim[k]), 3'd0});
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
